// File: rtl/mem_bus2_pkg.sv
// Shared definitions for the two-wire memory bus line initiator:
// bus command codes, FSM states and bus geometry.
package mem_bus2_pkg;

  localparam int unsigned ADDR_BITS      = 15;
  localparam int unsigned DATA_BITS      = 16;
  localparam int unsigned CTRL_BITS      = 2;
  localparam int unsigned LINE_BYTES     = 32;
  localparam int unsigned LINE_BITS      = LINE_BYTES * 8;
  localparam int unsigned BEATS          = LINE_BITS / DATA_BITS;
  localparam int unsigned BEAT_BITS      = $clog2(BEATS);
  localparam int unsigned TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_RESP       = 2'd1,
    C2_READ_LINE  = 2'd2,
    C2_WRITE_LINE = 2'd3
  } c2_code_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WR_WAIT = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/mem_bus2_line_buf.sv
// Line serializer/deserializer: holds one cache line and walks it beat by beat,
// presenting a registered outgoing word and capturing incoming words in place.
module mem_bus2_line_buf
  import mem_bus2_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_BITS,
  parameter int unsigned WORD_W = DATA_BITS,
  parameter int unsigned IDX_W  = $clog2(LINE_W / WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              clear,
  input  logic              shift,
  input  logic              capture,
  input  logic [WORD_W-1:0] word_in,
  output logic [LINE_W-1:0] line,
  output logic [WORD_W-1:0] word_out,
  output logic              last_beat
);

  localparam int unsigned NUM_BEATS = LINE_W / WORD_W;

  logic [LINE_W-1:0] line_r;
  logic [WORD_W-1:0] word_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nxt_s;

  assign idx_nxt_s = idx_r + IDX_W'(1);
  assign last_beat = (idx_r == IDX_W'(NUM_BEATS - 1));
  assign line      = line_r;
  assign word_out  = word_r;

  // Line storage, beat index and the pre-fetched outgoing word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_r <= '0;
      word_r <= '0;
      idx_r  <= '0;
    end else if (load) begin
      line_r <= load_line;
      word_r <= load_line[WORD_W-1:0];
      idx_r  <= '0;
    end else if (clear) begin
      idx_r  <= '0;
    end else if (shift) begin
      word_r <= line_r[int'(idx_nxt_s)*WORD_W +: WORD_W];
      idx_r  <= idx_nxt_s;
    end else if (capture) begin
      line_r[int'(idx_r)*WORD_W +: WORD_W] <= word_in;
      idx_r  <= idx_nxt_s;
    end
  end

endmodule

// File: rtl/mem_bus2_initiator.sv
// Cache-side initiator for the two-wire memory bus: turns one line request into
// a command, wait and 16-beat data phase with a response timeout.
module mem_bus2_initiator
  import mem_bus2_pkg::*;
#(
  parameter int unsigned ADDR2_BUS_SIZE  = ADDR_BITS,
  parameter int unsigned DATA2_BUS_SIZE  = DATA_BITS,
  parameter int unsigned CTR2_BUS_SIZE   = CTRL_BITS,
  parameter int unsigned CACHE_LINE_SIZE = LINE_BYTES,
  parameter int unsigned TIMEOUT         = TIMEOUT_CYCLES
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  output logic [ADDR2_BUS_SIZE-1:0]    A2,
  inout  wire  [DATA2_BUS_SIZE-1:0]    D2,
  inout  wire  [CTR2_BUS_SIZE-1:0]     C2,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR2_BUS_SIZE-1:0]    req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0] req_wdata,
  output logic                         resp_valid,
  output logic [CACHE_LINE_SIZE*8-1:0] resp_rdata,
  output logic                         resp_err
);

  localparam int unsigned LINE_W = CACHE_LINE_SIZE * 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  state_e                     state_r, state_n;
  logic [ADDR2_BUS_SIZE-1:0]  addr_r, addr_n;
  logic                       err_r, err_n;
  logic [CNT_W-1:0]           cnt_r, cnt_n;
  logic                       c2_oe_r, d2_oe_r;
  logic [CTR2_BUS_SIZE-1:0]   c2_val_r;
  logic                       buf_load_s, buf_clear_s, buf_shift_s, buf_capture_s;
  logic                       last_beat_s, resp_seen_s, timed_out_s;
  logic [DATA2_BUS_SIZE-1:0]  buf_word_s;

  // X or Z on C2 compares unknown and therefore never counts as a response
  assign resp_seen_s = (C2 == CTR2_BUS_SIZE'(C2_RESP));
  assign timed_out_s = (cnt_r == CNT_W'(TIMEOUT - 1));

  assign C2 = c2_oe_r ? c2_val_r   : {CTR2_BUS_SIZE{1'bz}};
  assign D2 = d2_oe_r ? buf_word_s : {DATA2_BUS_SIZE{1'bz}};

  mem_bus2_line_buf #(
    .LINE_W (LINE_W),
    .WORD_W (DATA2_BUS_SIZE)
  ) u_line_buf (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .load      (buf_load_s),
    .load_line (req_wdata),
    .clear     (buf_clear_s),
    .shift     (buf_shift_s),
    .capture   (buf_capture_s),
    .word_in   (D2),
    .line      (resp_rdata),
    .word_out  (buf_word_s),
    .last_beat (last_beat_s)
  );

  // Next-state, wait counter and line-buffer control
  always_comb begin
    state_n       = state_r;
    addr_n        = addr_r;
    err_n         = err_r;
    cnt_n         = cnt_r;
    buf_load_s    = 1'b0;
    buf_clear_s   = 1'b0;
    buf_shift_s   = 1'b0;
    buf_capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          addr_n = req_addr;
          err_n  = 1'b0;
          if (req_write) begin
            state_n    = ST_WR_DATA;
            buf_load_s = 1'b1;
          end else begin
            state_n     = ST_RD_CMD;
            buf_clear_s = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RD_CMD: begin
        state_n = ST_RD_WAIT;
        cnt_n   = '0;
      end
      ST_RD_WAIT: begin
        if (resp_seen_s) begin
          state_n       = ST_RD_DATA;
          buf_capture_s = 1'b1;
        end else if (timed_out_s) begin
          state_n = ST_DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      ST_RD_DATA: begin
        buf_capture_s = 1'b1;
        if (last_beat_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_RD_DATA;
        end
      end
      ST_WR_DATA: begin
        if (last_beat_s) begin
          state_n = ST_WR_WAIT;
          cnt_n   = '0;
        end else begin
          buf_shift_s = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (resp_seen_s) begin
          state_n = ST_DONE;
        end else if (timed_out_s) begin
          state_n = ST_DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered bus/handshake outputs, all derived from the next state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      err_r      <= 1'b0;
      cnt_r      <= '0;
      A2         <= '0;
      c2_oe_r    <= 1'b0;
      c2_val_r   <= '0;
      d2_oe_r    <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      state_r    <= state_n;
      addr_r     <= addr_n;
      err_r      <= err_n;
      cnt_r      <= cnt_n;
      A2         <= ((state_n == ST_IDLE) || (state_n == ST_DONE)) ? '0 : addr_n;
      c2_oe_r    <= (state_n == ST_RD_CMD) ||
                    ((state_r == ST_IDLE) && (state_n == ST_WR_DATA));
      c2_val_r   <= (state_n == ST_RD_CMD) ? CTR2_BUS_SIZE'(C2_READ_LINE)
                                           : CTR2_BUS_SIZE'(C2_WRITE_LINE);
      d2_oe_r    <= (state_n == ST_WR_DATA);
      req_ready  <= (state_n == ST_IDLE);
      resp_valid <= (state_n == ST_DONE);
      resp_err   <= (state_n == ST_DONE) && err_n;
    end
  end

endmodule
